// File: rtl/alu_branch_unit_pkg.sv
// Shared definitions for the execute-stage ALU / branch resolver.
// Holds the ALUControl operation codes, the one-hot branch bit positions
// and the bit positions of the NZCV flags within the 4-bit flags bus.
package alu_branch_unit_pkg;

    // ALUControl operation codes (1010-1111 are undefined and yield 0)
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // Bit positions in the one-hot branch bus
    localparam int unsigned BEQ_BIT  = 0;
    localparam int unsigned BNE_BIT  = 1;
    localparam int unsigned BLT_BIT  = 2;
    localparam int unsigned BGE_BIT  = 3;
    localparam int unsigned BLTU_BIT = 4;
    localparam int unsigned BGEU_BIT = 5;

    // Bit positions in the flags bus {N, Z, C, V}
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_branch_unit_alu.sv
// Integer ALU: 32-bit result plus NZCV flags from two operands.
// Ports:
//   srcA, srcB   in  32  operands (shift amount is srcB[4:0])
//   ALUControl   in  4   operation select
//   ALUResult    out 32  combinational result
//   flags        out 4   combinational {N, Z, C, V}
module ALU
    import alu_branch_unit_pkg::*;
(
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [3:0]  ALUControl,
    output logic [31:0] ALUResult,
    output logic [3:0]  flags
);

    logic        is_sub;
    logic [31:0] b_eff;
    logic [32:0] sum;
    logic        carry;
    logic        ovf;

    // ADD and SUB share one adder; SUB is A + ~B + 1 so C=1 means no borrow.
    assign is_sub = (ALUControl == ALU_SUB);
    assign b_eff  = is_sub ? ~srcB : srcB;
    assign sum    = {1'b0, srcA} + {1'b0, b_eff} + {32'd0, is_sub};

    always_comb begin
        ALUResult = '0;
        carry     = 1'b0;
        ovf       = 1'b0;
        case (ALUControl)
            ALU_ADD: begin
                ALUResult = sum[31:0];
                carry     = sum[32];
                ovf       = (srcA[31] == srcB[31]) && (sum[31] != srcA[31]);
            end
            ALU_SUB: begin
                ALUResult = sum[31:0];
                carry     = sum[32];
                ovf       = (srcA[31] != srcB[31]) && (sum[31] != srcA[31]);
            end
            ALU_AND:  ALUResult = srcA & srcB;
            ALU_OR:   ALUResult = srcA | srcB;
            ALU_SLT:  ALUResult = {31'd0, $signed(srcA) < $signed(srcB)};
            ALU_SLL:  ALUResult = srcA << srcB[4:0];
            ALU_SLTU: ALUResult = {31'd0, srcA < srcB};
            ALU_XOR:  ALUResult = srcA ^ srcB;
            ALU_SRL:  ALUResult = srcA >> srcB[4:0];
            ALU_SRA:  ALUResult = $unsigned($signed(srcA) >>> srcB[4:0]);
            default:  ALUResult = '0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = ALUResult[31];
        flags[FLAG_Z] = (ALUResult == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu_branch_unit_branchjump.sv
// Branch/jump resolver: decides whether the next PC is the branch/jump target.
// Ports:
//   branch     in  6  one-hot branch type {BGEU, BLTU, BGE, BLT, BNE, BEQ}
//   jump       in  1  unconditional jump request
//   ALUFlags   in  4  {N, Z, C, V} from the ALU (meaningful after SUB)
//   PCNextSrc  out 1  1 selects the branch/jump target
module branchJump
    import alu_branch_unit_pkg::*;
(
    input  logic [5:0] branch,
    input  logic       jump,
    input  logic [3:0] ALUFlags,
    output logic       PCNextSrc
);

    logic n, z, c, v;
    logic [5:0] cond;

    assign n = ALUFlags[FLAG_N];
    assign z = ALUFlags[FLAG_Z];
    assign c = ALUFlags[FLAG_C];
    assign v = ALUFlags[FLAG_V];

    always_comb begin
        cond           = '0;
        cond[BEQ_BIT]  = z;
        cond[BNE_BIT]  = ~z;
        cond[BLT_BIT]  = n ^ v;
        cond[BGE_BIT]  = ~(n ^ v);
        cond[BLTU_BIT] = ~c;
        cond[BGEU_BIT] = c;
    end

    // Several asserted branch bits simply OR their conditions together.
    assign PCNextSrc = jump | (|(branch & cond));

endmodule

// File: rtl/alu_branch_unit.sv
// Execute-stage ALU plus branch/jump resolver with a registered output copy.
// Ports:
//   clk, reset                    in   clock; sync active-high reset (registers only)
//   srcA, srcB                    in   32-bit operands
//   ALUControl                    in   4-bit operation select
//   branch, jump                  in   one-hot branch type, jump request
//   ALUResult, flags, PCNextSrc   out  combinational outputs
//   ALUResult_q, flags_q,
//   PCNextSrc_q                   out  same values registered on rising clk
module alu_branch_unit
    import alu_branch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [3:0]  ALUControl,
    input  logic [5:0]  branch,
    input  logic        jump,
    output logic [31:0] ALUResult,
    output logic [3:0]  flags,
    output logic        PCNextSrc,
    output logic [31:0] ALUResult_q,
    output logic [3:0]  flags_q,
    output logic        PCNextSrc_q
);

    ALU u_alu (
        .srcA       (srcA),
        .srcB       (srcB),
        .ALUControl (ALUControl),
        .ALUResult  (ALUResult),
        .flags      (flags)
    );

    branchJump u_branch_jump (
        .branch    (branch),
        .jump      (jump),
        .ALUFlags  (flags),
        .PCNextSrc (PCNextSrc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ALUResult_q <= '0;
            flags_q     <= '0;
            PCNextSrc_q <= 1'b0;
        end else begin
            ALUResult_q <= ALUResult;
            flags_q     <= flags;
            PCNextSrc_q <= PCNextSrc;
        end
    end

endmodule

// File: tb/tb_alu_branch_unit.sv
module tb_alu_branch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [3:0]  ALUControl;
    logic [5:0]  branch;
    logic        jump;
    logic [31:0] ALUResult;
    logic [3:0]  flags;
    logic        PCNextSrc;
    logic [31:0] ALUResult_q;
    logic [3:0]  flags_q;
    logic        PCNextSrc_q;

    int errors = 0;
    int checks = 0;

    alu_branch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .srcA        (srcA),
        .srcB        (srcB),
        .ALUControl  (ALUControl),
        .branch      (branch),
        .jump        (jump),
        .ALUResult   (ALUResult),
        .flags       (flags),
        .PCNextSrc   (PCNextSrc),
        .ALUResult_q (ALUResult_q),
        .flags_q     (flags_q),
        .PCNextSrc_q (PCNextSrc_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic [5:0]  br;
        logic        jmp;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags;
        logic        exp_pc;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // {a, b, ctl, branch, jump, result, flags NZCV, PCNextSrc}
        vecs[0]  = '{32'd35,        32'd35,        4'b0000, 6'b000000, 1'b0, 32'd70,        4'b0000, 1'b0}; // ADD
        vecs[1]  = '{32'd35,        32'd35,        4'b0001, 6'b000001, 1'b0, 32'd0,         4'b0110, 1'b1}; // SUB BEQ
        vecs[2]  = '{32'd35,        32'd35,        4'b0001, 6'b000010, 1'b0, 32'd0,         4'b0110, 1'b0}; // SUB BNE
        vecs[3]  = '{32'h7FFFFFFF,  32'hFFFFFFFF,  4'b0001, 6'b000100, 1'b0, 32'h80000000,  4'b1001, 1'b0}; // BLT
        vecs[4]  = '{32'h7FFFFFFF,  32'hFFFFFFFF,  4'b0001, 6'b001000, 1'b0, 32'h80000000,  4'b1001, 1'b1}; // BGE
        vecs[5]  = '{32'h7FFFFFFF,  32'hFFFFFFFF,  4'b0001, 6'b010000, 1'b0, 32'h80000000,  4'b1001, 1'b1}; // BLTU
        vecs[6]  = '{32'h7FFFFFFF,  32'hFFFFFFFF,  4'b0001, 6'b100000, 1'b0, 32'h80000000,  4'b1001, 1'b0}; // BGEU
        vecs[7]  = '{32'h80000000,  32'd4,         4'b1001, 6'b000000, 1'b0, 32'hF8000000,  4'b1000, 1'b0}; // SRA
        vecs[8]  = '{32'h80000000,  32'd4,         4'b1000, 6'b000000, 1'b0, 32'h08000000,  4'b0000, 1'b0}; // SRL
        vecs[9]  = '{32'd1,         32'd31,        4'b0101, 6'b000000, 1'b0, 32'h80000000,  4'b1000, 1'b0}; // SLL
        vecs[10] = '{32'hFFFFFFFF,  32'd1,         4'b0100, 6'b000000, 1'b0, 32'd1,         4'b0000, 1'b0}; // SLT
        vecs[11] = '{32'hFFFFFFFF,  32'd1,         4'b0110, 6'b000000, 1'b0, 32'd0,         4'b0100, 1'b0}; // SLTU
        vecs[12] = '{32'h0000F0F0,  32'h00000FF0,  4'b0010, 6'b000000, 1'b1, 32'h000000F0,  4'b0000, 1'b1}; // AND + jump
        vecs[13] = '{32'h00000F00,  32'h000000F0,  4'b0011, 6'b000000, 1'b0, 32'h00000FF0,  4'b0000, 1'b0}; // OR
        vecs[14] = '{32'hFFFF0000,  32'hFF00FF00,  4'b0111, 6'b000000, 1'b0, 32'h00FFFF00,  4'b0000, 1'b0}; // XOR
        vecs[15] = '{32'h7FFFFFFF,  32'd1,         4'b0000, 6'b000000, 1'b0, 32'h80000000,  4'b1001, 1'b0}; // ADD ovf
        vecs[16] = '{32'hFFFFFFFF,  32'd1,         4'b0000, 6'b000000, 1'b0, 32'd0,         4'b0110, 1'b0}; // ADD carry
        vecs[17] = '{32'd5,         32'd3,         4'b1010, 6'b000000, 1'b0, 32'd0,         4'b0100, 1'b0}; // undef
        vecs[18] = '{32'd5,         32'd3,         4'b1111, 6'b000001, 1'b0, 32'd0,         4'b0100, 1'b1}; // undef BEQ
        vecs[19] = '{32'd3,         32'd5,         4'b0001, 6'b010000, 1'b0, 32'hFFFFFFFE,  4'b1000, 1'b1}; // SUB BLTU
        vecs[20] = '{32'd1,         32'h00000021,  4'b0101, 6'b000000, 1'b0, 32'd2,         4'b0000, 1'b0}; // SLL amt mod 32
        vecs[21] = '{32'd3,         32'd5,         4'b0001, 6'b001100, 1'b0, 32'hFFFFFFFE,  4'b1000, 1'b1}; // BLT|BGE ORed
        vecs[22] = '{32'd0,         32'd0,         4'b0001, 6'b000000, 1'b1, 32'd0,         4'b0110, 1'b1}; // jump, SUB
        vecs[23] = '{32'd9,         32'd9,         4'b0001, 6'b100010, 1'b0, 32'd0,         4'b0110, 1'b1}; // BNE|BGEU

        reset = 1'b0; srcA = '0; srcB = '0; ALUControl = '0; branch = '0; jump = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            srcA = vecs[i].a; srcB = vecs[i].b; ALUControl = vecs[i].ctl;
            branch = vecs[i].br; jump = vecs[i].jmp;
            #1;
            check($sformatf("vec%0d result", i), ALUResult, vecs[i].exp_res);
            check($sformatf("vec%0d flags", i), {28'd0, flags}, {28'd0, vecs[i].exp_flags});
            check($sformatf("vec%0d pcnext", i), {31'd0, PCNextSrc}, {31'd0, vecs[i].exp_pc});
        end

        // Reset clears registers but leaves combinational outputs alone.
        @(negedge clk);
        reset = 1'b1; srcA = 32'd35; srcB = 32'd35; ALUControl = 4'b0000; branch = '0; jump = 1'b1;
        @(posedge clk); #1;
        check("reset result_q", ALUResult_q, 32'd0);
        check("reset flags_q", {28'd0, flags_q}, 32'd0);
        check("reset pcnext_q", {31'd0, PCNextSrc_q}, 32'd0);
        check("reset comb result", ALUResult, 32'd70);
        check("reset comb pcnext", {31'd0, PCNextSrc}, 32'd1);

        @(negedge clk);
        reset = 1'b0; srcA = 32'd2; srcB = 32'd3; ALUControl = 4'b0000; jump = 1'b0;
        #1;
        check("pre-edge result_q held", ALUResult_q, 32'd0);
        @(posedge clk); #1;
        check("capture result_q", ALUResult_q, 32'd5);
        check("capture flags_q", {28'd0, flags_q}, 32'd0);
        check("capture pcnext_q", {31'd0, PCNextSrc_q}, 32'd0);

        // Capture a taken branch, then check the value holds one cycle later.
        @(negedge clk);
        srcA = 32'd7; srcB = 32'd7; ALUControl = 4'b0001; branch = 6'b000001;
        @(posedge clk); #1;
        check("beq result_q", ALUResult_q, 32'd0);
        check("beq flags_q", {28'd0, flags_q}, 32'h6);
        check("beq pcnext_q", {31'd0, PCNextSrc_q}, 32'd1);

        @(negedge clk);
        srcA = 32'h7FFFFFFF; srcB = 32'hFFFFFFFF; branch = 6'b000000;
        @(posedge clk); #1;
        check("sub ovf result_q", ALUResult_q, 32'h80000000);
        check("sub ovf flags_q", {28'd0, flags_q}, 32'h9);
        check("sub ovf pcnext_q", {31'd0, PCNextSrc_q}, 32'd0);

        // Reset asserted while inputs would otherwise be captured.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset override result_q", ALUResult_q, 32'd0);
        check("reset override flags_q", {28'd0, flags_q}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_branch_unit.md
# alu_branch_unit

Execute-stage datapath block combining the integer ALU and the branch/jump resolver of the RISC-V-style core. It computes a 32-bit result and NZCV flags from two operands, and raises PCNextSrc when a jump is requested or the selected branch condition holds on those flags. Result, flags and PCNextSrc are combinational; a registered copy of each is also provided for the pipeline.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  single clock; only the registered outputs use it.
- reset  in  1  synchronous, active-high; clears the registered outputs only.
- srcA  in  32  operand A.
- srcB  in  32  operand B; shift amount is srcB[4:0].
- ALUControl  in  4  operation select.
- branch  in  6  one-hot branch type: [0] BEQ, [1] BNE, [2] BLT, [3] BGE, [4] BLTU, [5] BGEU.
- jump  in  1  unconditional jump request.
- ALUResult  out  32  combinational result.
- flags  out  4  combinational {N, Z, C, V} = flags[3:0].
- PCNextSrc  out  1  combinational; 1 selects the branch/jump target.
- ALUResult_q, flags_q, PCNextSrc_q  out  32/4/1  values of the above captured on rising clk.

## Operation
- ALUControl encodings:
  - 0000 ADD: A+B
  - 0001 SUB: A−B
  - 0010 AND
  - 0011 OR
  - 0100 SLT: signed A<B → 1, else 0
  - 0101 SLL: A<<B[4:0]
  - 0110 SLTU: unsigned compare, 1/0
  - 0111 XOR
  - 1000 SRL: logical right shift
  - 1001 SRA: arithmetic right shift
  - 1010–1111: result 0
- N = ALUResult[31]; Z = (ALUResult == 0), for every op.
- ADD: C = carry-out of the 33-bit sum. V = operands have the same sign and the result sign differs.
- SUB: computed as A + ~B + 1. C = carry-out, so C=1 means A ≥ B unsigned (no borrow). V = operands have different signs and the result sign differs from A.
- All other ops: C = V = 0.
- Branch condition for each asserted branch bit:
  - BEQ: Z
  - BNE: !Z
  - BLT: N^V
  - BGE: !(N^V)
  - BLTU: !C
  - BGEU: C
- Branch conditions are valid only when the control unit selects SUB; the block does not enforce this.
- PCNextSrc = jump OR (OR over asserted branch bits of their condition).
- branch = 0 and jump = 0 gives PCNextSrc = 0.
- Multiple asserted branch bits are ORed; this is legal but never issued by the decoder.
- Undefined ALUControl still produces flags from result 0: Z=1, N=C=V=0.

## Timing
- Combinational path srcA/srcB/ALUControl/branch/jump → ALUResult/flags/PCNextSrc with zero latency; outputs are valid in the same cycle.
- Registered outputs capture the combinational values on each rising clk, giving 1-cycle latency.
- reset high at a rising edge clears ALUResult_q, flags_q and PCNextSrc_q to 0; it overrides capture in that cycle.
- reset has no effect on the combinational outputs.
- No handshake and no internal state other than the output registers.

## Structure
- Shared package holds:
  - ALUControl localparams (ADD…SRA)
  - branch bit indices (BEQ_BIT…BGEU_BIT)
  - flag bit indices (N=3, Z=2, C=1, V=0)
- Sub-modules:
  - ALU: srcA, srcB, ALUControl → ALUResult, flags.
  - branchJump: branch, jump, ALUFlags → PCNextSrc.
- The top wires the ALU flags into branchJump and holds the output register stage.

## Test plan
- ADD 35+35, branch=0, jump=0 → ALUResult=70, flags=0000, PCNextSrc=0.
- SUB 35−35 with BEQ (branch=000001) → ALUResult=0, flags=0110 (Z,C), PCNextSrc=1. The same inputs with BNE give PCNextSrc=0.
- SUB 0x7FFFFFFF−0xFFFFFFFF → ALUResult=0x80000000, N=1, C=0, V=1.
  - BLT → 0; BGE → 1; BLTU → 1; BGEU → 0.
- Logic and shift ops:
  - SRA 0x80000000 by 4 → 0xF8000000
  - SRL 0x80000000 by 4 → 0x08000000
  - SLL 1 by 31 → 0x80000000
  - SLT(−1,1) → 1; SLTU(−1,1) → 0
- jump=1 with branch=0 and any op → PCNextSrc=1.
- Registered outputs:
  - reset=1 for one edge → all _q outputs 0.
  - Release reset, apply ADD 2+3 → ALUResult_q=5 on the following edge.
